// File: rtl/bias_add_5.sv
// Per-channel bias add for a channel-interleaved accumulator stream.
// Each frame first loads NUM_CH biases, then adds, shifts and saturates NUM_PIX*NUM_CH words.
`ifndef BIAS_COEFF_WIDTH
`define BIAS_COEFF_WIDTH 16
`endif
`ifndef BIAS_NUM_CH
`define BIAS_NUM_CH 4
`endif

module bias_add_5 #(
  parameter int COEFF_WIDTH = `BIAS_COEFF_WIDTH,
  parameter int ACC_WIDTH   = 32,
  parameter int OUT_WIDTH   = `BIAS_COEFF_WIDTH,
  parameter int NUM_CH      = `BIAS_NUM_CH,
  parameter int NUM_PIX     = 64,
  parameter int SHIFT       = 8
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic [COEFF_WIDTH-1:0] bias_V_dout,
  input  logic                   bias_V_empty_n,
  output logic                   bias_V_read,
  input  logic [ACC_WIDTH-1:0]   acc_V_dout,
  input  logic                   acc_V_empty_n,
  output logic                   acc_V_read,
  output logic [OUT_WIDTH-1:0]   output_V_din,
  input  logic                   output_V_full_n,
  output logic                   output_V_write
);

  localparam int CH_W  = (NUM_CH  > 1) ? $clog2(NUM_CH)  : 1;
  localparam int PIX_W = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
  localparam int SUM_W = ACC_WIDTH + 1;

  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    {{(SUM_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic {LOAD, RUN} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CH_W-1:0]         r_ch_cnt;
  logic [PIX_W-1:0]        r_pix_cnt;
  logic [COEFF_WIDTH-1:0]  r_bias [NUM_CH];
  logic                    r_out_valid;
  logic [OUT_WIDTH-1:0]    r_out_data;

  logic                    w_bias_pop;
  logic                    w_acc_pop;
  logic                    w_out_write;
  logic                    w_ch_last;
  logic                    w_pix_last;
  logic signed [SUM_W-1:0] w_bias_ext;
  logic signed [SUM_W-1:0] w_acc_ext;
  logic signed [SUM_W-1:0] w_sum;
  logic signed [SUM_W-1:0] w_shifted;
  logic [OUT_WIDTH-1:0]    w_result;

  assign w_ch_last  = (r_ch_cnt  == CH_W'(NUM_CH - 1));
  assign w_pix_last = (r_pix_cnt == PIX_W'(NUM_PIX - 1));

  // Handshakes are gated by reset so all pops/pushes are forced low while held in reset.
  assign w_bias_pop  = ap_rst_n & (r_state == LOAD) & bias_V_empty_n;
  assign w_acc_pop   = ap_rst_n & (r_state == RUN) & acc_V_empty_n
                       & (~r_out_valid | output_V_full_n);
  assign w_out_write = ap_rst_n & r_out_valid & output_V_full_n;

  assign bias_V_read    = w_bias_pop;
  assign acc_V_read     = w_acc_pop;
  assign output_V_write = w_out_write;
  assign output_V_din   = r_out_data;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LOAD: if (w_bias_pop && w_ch_last) w_state_nxt = RUN;
      RUN:  if (w_acc_pop && w_ch_last && w_pix_last) w_state_nxt = LOAD;
      default: w_state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state   <= LOAD;
      r_ch_cnt  <= '0;
      r_pix_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_bias_pop) begin
        r_ch_cnt <= w_ch_last ? '0 : r_ch_cnt + 1'b1;
      end else if (w_acc_pop) begin
        r_ch_cnt <= w_ch_last ? '0 : r_ch_cnt + 1'b1;
        if (w_ch_last) r_pix_cnt <= w_pix_last ? '0 : r_pix_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (w_bias_pop) r_bias[r_ch_cnt] <= bias_V_dout;
  end

  always_comb begin
    w_bias_ext = SUM_W'($signed(r_bias[r_ch_cnt]));
    w_acc_ext  = SUM_W'($signed(acc_V_dout));
    w_sum      = w_acc_ext + w_bias_ext;
    w_shifted  = w_sum >>> SHIFT;
    if (w_shifted > SAT_MAX)      w_result = SAT_MAX[OUT_WIDTH-1:0];
    else if (w_shifted < SAT_MIN) w_result = SAT_MIN[OUT_WIDTH-1:0];
    else                          w_result = w_shifted[OUT_WIDTH-1:0];
  end

  // A pop in the same cycle as a write refills the register, keeping one word per cycle.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_acc_pop) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_result;
    end else if (w_out_write) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/bias_add_5.md
BIAS_ADD_5 -- requirements
Module: bias_add_5

Interface
REQ-001 SHALL have parameter COEFF_WIDTH, default `coeff_width, width of the bias words.
REQ-002 SHALL have parameter ACC_WIDTH, default 32, width of the signed convolution accumulator words.
REQ-003 SHALL have parameter OUT_WIDTH, default `coeff_width, width of the result words.
REQ-004 SHALL have parameter NUM_CH, default `kern_s_k_5, number of output channels (biases per frame).
REQ-005 SHALL have parameter NUM_PIX, default 64, number of output pixels per frame.
REQ-006 SHALL have parameter SHIFT, default 8, arithmetic right shift applied after the add.
REQ-007 SHALL have port ap_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-008 SHALL have port ap_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-009 SHALL have port bias_V_dout, input, COEFF_WIDTH bits: signed bias word from the upstream bias FIFO.
REQ-010 SHALL have port bias_V_empty_n, input, 1 bit: bias FIFO holds data.
REQ-011 SHALL have port bias_V_read, output, 1 bit: pop one bias word.
REQ-012 SHALL have port acc_V_dout, input, ACC_WIDTH bits: signed accumulator word.
REQ-013 SHALL have port acc_V_empty_n, input, 1 bit: accumulator FIFO holds data.
REQ-014 SHALL have port acc_V_read, output, 1 bit: pop one accumulator word.
REQ-015 SHALL have port output_V_din, output, OUT_WIDTH bits: result word.
REQ-016 SHALL have port output_V_full_n, input, 1 bit: downstream FIFO has space.
REQ-017 SHALL have port output_V_write, output, 1 bit: push one result word.

Function
REQ-018 SHALL implement FSM states LOAD and RUN.
- In LOAD, bias_V_read = bias_V_empty_n.
- Each popped bias is stored in register bank entry ch_cnt, and ch_cnt increments.
- After entry NUM_CH-1 is stored, the FSM moves to RUN with ch_cnt=0 and pix_cnt=0.
REQ-019 SHALL never assert bias_V_read in RUN, and never assert acc_V_read in LOAD.
REQ-020 SHALL assert acc_V_read = RUN & acc_V_empty_n & (!out_valid | output_V_full_n), combinationally.
REQ-021 SHALL assign each accumulator word, in the order received, to channel ch_cnt; the stream is channel-interleaved, all NUM_CH channels of a pixel before the next pixel.
REQ-022 SHALL, on each acc pop, compute the result into the output register, with out_valid set on the next cycle (latency 1):
- sum = acc + sign-extended bias[ch_cnt], at ACC_WIDTH+1 bits;
- arithmetic shift right by SHIFT, truncating toward minus infinity;
- saturate to the signed OUT_WIDTH range.
REQ-023 SHALL advance the counters on each acc pop:
- ch_cnt wraps from NUM_CH-1 to 0;
- pix_cnt increments on each ch_cnt wrap.
REQ-024 SHALL return to LOAD after popping the word with pix_cnt=NUM_PIX-1 and ch_cnt=NUM_CH-1, so that new biases are loaded for the next frame.
REQ-025 SHALL drive output_V_write = out_valid & output_V_full_n.
- out_valid clears on a write that has no simultaneous acc pop.
- A simultaneous write and pop keeps out_valid=1 with the new data, giving full throughput of 1 word/cycle.
REQ-026 SHALL hold output_V_din stable while out_valid=1 and output_V_full_n=0.
REQ-027 SHALL, when the FSM moves to LOAD with out_valid=1, still drain that word; LOAD of the next frame proceeds in parallel.

Reset
REQ-028 SHALL, while ap_rst_n=0, asynchronously force:
- state to LOAD;
- ch_cnt and pix_cnt to 0;
- out_valid to 0, and output_V_din to 0;
- bias_V_read, acc_V_read and output_V_write to 0.
The bias bank SHALL need no reset.
REQ-029 SHALL discard any partially loaded bias set or partial frame when reset is asserted mid-operation, and restart in LOAD after release.

Verification
REQ-030 SHALL cover bias load and pass-through.
- Stimulus: NUM_CH=4, SHIFT=0, biases {1,-2,3,-4}, acc stream {10,10,10,10}.
- Required response: outputs {11,8,13,6}, with the first output one cycle after its acc pop.
REQ-031 SHALL cover saturation.
- Stimulus: OUT_WIDTH=16, SHIFT=0, bias 0.
- Required response: acc 40000 -> 32767; acc -40000 -> -32768.
REQ-032 SHALL cover the shift.
- Stimulus: SHIFT=8, bias 0.
- Required response: acc -1 -> -1; acc 511 -> 1.
REQ-033 SHALL cover backpressure.
- Stimulus: output_V_full_n=0 for 5 cycles with out_valid=1.
- Required response: output_V_din stable, acc_V_read=0, no words lost or duplicated after release.
REQ-034 SHALL cover the frame boundary.
- Stimulus: NUM_PIX=2, second bias set {100,...}.
- Required response: the 2*NUM_CH+1-th output uses the new biases, and no acc pop occurs during LOAD.
REQ-035 SHALL cover reset mid-frame.
- Stimulus: assert ap_rst_n=0 after 3 acc pops.
- Required response: all outputs 0 immediately, and the next pops after release are bias reads.
